// File: rtl/vend_pkg.sv
// Shared vending-controller types: FSM states, coin codes, prices, widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vend_pkg;

   localparam int CREDIT_W  = 4;
   localparam int STOCK_W   = 3;
   localparam int ITEM_W    = 2;
   localparam int NUM_ITEMS = 4;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_CREDIT   = 2'd1,
      S_DISPENSE = 2'd2,
      S_CHANGE   = 2'd3
   } state_t;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_5    = 2'b01;
   localparam logic [1:0] COIN_10   = 2'b10;

   // Prices in 5-cent units
   localparam logic [CREDIT_W-1:0] PRICE0 = 4'd3;
   localparam logic [CREDIT_W-1:0] PRICE1 = 4'd4;
   localparam logic [CREDIT_W-1:0] PRICE2 = 4'd5;
   localparam logic [CREDIT_W-1:0] PRICE3 = 4'd6;

   function automatic logic [CREDIT_W-1:0] price_of(input logic [ITEM_W-1:0] item);
      logic [CREDIT_W-1:0] p;
      case (item)
         2'd0:    p = PRICE0;
         2'd1:    p = PRICE1;
         2'd2:    p = PRICE2;
         default: p = PRICE3;
      endcase
      return p;
   endfunction

   // Coin code to value in units; the two invalid codes are worth nothing
   function automatic logic [1:0] coin_units(input logic [1:0] code);
      logic [1:0] u;
      case (code)
         COIN_5:  u = 2'd1;
         COIN_10: u = 2'd2;
         default: u = 2'd0;
      endcase
      return u;
   endfunction

endpackage

// File: rtl/vend_stock.sv
// Per-product stock counters with single-slot decrement and global reload.
// Latency: counts update one cycle after dec/load; sold_out follows counts combinationally.
// Backpressure: none; a decrement of an empty slot is ignored.
module vend_stock
   import vend_pkg::*;
#(
   parameter int STOCK_INIT = 7
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 dec,
   input  logic [ITEM_W-1:0]    dec_sel,
   input  logic                 load,
   output logic [NUM_ITEMS-1:0] sold_out
);

   localparam logic [STOCK_W-1:0] INIT_CNT = STOCK_W'(STOCK_INIT);

   for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_slot
      logic [STOCK_W-1:0] cnt;

      // Reload on restock, otherwise count down when this slot is vended
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            cnt <= INIT_CNT;
         end else if (load) begin
            cnt <= INIT_CNT;
         end else if (dec && (dec_sel == ITEM_W'(g)) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
         end
      end

      assign sold_out[g] = (cnt == '0);
   end

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: credit accumulation, product vend handshake, unit-by-unit change return.
// Latency: credit/strobe outputs are registered, visible one cycle after the triggering input.
// Backpressure: disp_req held until disp_done; coins rejected and selections ignored while busy.
module vend_ctrl
   import vend_pkg::*;
#(
   parameter int STOCK_INIT = 7,
   parameter int CREDIT_MAX = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [1:0]           coin,
   input  logic                 sel_valid,
   input  logic [ITEM_W-1:0]    sel,
   input  logic                 cancel,
   input  logic                 disp_done,
   input  logic                 restock,
   output logic [CREDIT_W-1:0]  credit,
   output logic                 disp_req,
   output logic [ITEM_W-1:0]    disp_item,
   output logic                 change_pulse,
   output logic                 coin_reject,
   output logic                 deny,
   output logic [NUM_ITEMS-1:0] sold_out,
   output logic                 busy
);

   localparam logic [CREDIT_W:0] CMAX = (CREDIT_W+1)'(CREDIT_MAX);

   state_t              state;
   logic [1:0]          coin_val;
   logic                coin_in;
   logic [CREDIT_W:0]   credit_sum;
   logic [CREDIT_W-1:0] price;
   logic                vend_ok;
   logic                restock_ok;

   // Decode coin value, selection price and whether a vend can be granted this cycle
   always_comb begin
      coin_val   = coin_units(coin);
      coin_in    = (coin_val != 2'd0);
      credit_sum = {1'b0, credit} + {3'b000, coin_val};
      price      = price_of(sel);
      vend_ok    = (state == S_CREDIT) && sel_valid && !cancel &&
                   (credit >= price) && !sold_out[sel];
      restock_ok = (state == S_IDLE) && restock;
   end

   vend_stock #(
      .STOCK_INIT (STOCK_INIT)
   ) u_stock (
      .clk      (clk),
      .reset    (reset),
      .dec      (vend_ok),
      .dec_sel  (sel),
      .load     (restock_ok),
      .sold_out (sold_out)
   );

   assign busy = (state == S_DISPENSE) || (state == S_CHANGE);

   // Controller FSM: state, credit and all registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         credit       <= '0;
         disp_item    <= '0;
         disp_req     <= 1'b0;
         change_pulse <= 1'b0;
         coin_reject  <= 1'b0;
         deny         <= 1'b0;
      end else begin
         coin_reject  <= 1'b0;
         deny         <= 1'b0;
         change_pulse <= 1'b0;
         case (state)
            S_IDLE: begin
               // Credit is zero here, so any valid coin fits
               if (coin_in) begin
                  credit <= credit_sum[CREDIT_W-1:0];
                  state  <= S_CREDIT;
               end
               if (sel_valid) begin
                  deny <= 1'b1;
               end
            end
            S_CREDIT: begin
               if (cancel) begin
                  coin_reject <= coin_in;
                  state       <= S_CHANGE;
               end else if (sel_valid) begin
                  coin_reject <= coin_in;
                  if (vend_ok) begin
                     credit    <= credit - price;
                     disp_item <= sel;
                     disp_req  <= 1'b1;
                     state     <= S_DISPENSE;
                  end else begin
                     deny <= 1'b1;
                  end
               end else if (coin_in) begin
                  if (credit_sum <= CMAX) begin
                     credit <= credit_sum[CREDIT_W-1:0];
                  end else begin
                     coin_reject <= 1'b1;
                  end
               end
            end
            S_DISPENSE: begin
               coin_reject <= coin_in;
               if (disp_done) begin
                  disp_req <= 1'b0;
                  state    <= (credit != '0) ? S_CHANGE : S_IDLE;
               end
            end
            S_CHANGE: begin
               // One pulse per remaining unit, then back to idle
               coin_reject <= coin_in;
               if (credit != '0) begin
                  change_pulse <= 1'b1;
                  credit       <= credit - 1'b1;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed self-checking bench for vend_ctrl.
// Latency: n/a.
// Backpressure: n/a.
module tb_vend_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] coin;
   logic       sel_valid;
   logic [1:0] sel;
   logic       cancel;
   logic       disp_done;
   logic       restock;
   logic [3:0] credit;
   logic       disp_req;
   logic [1:0] disp_item;
   logic       change_pulse;
   logic       coin_reject;
   logic       deny;
   logic [3:0] sold_out;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   vend_ctrl #(
      .STOCK_INIT (7),
      .CREDIT_MAX (15)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .coin         (coin),
      .sel_valid    (sel_valid),
      .sel          (sel),
      .cancel       (cancel),
      .disp_done    (disp_done),
      .restock      (restock),
      .credit       (credit),
      .disp_req     (disp_req),
      .disp_item    (disp_item),
      .change_pulse (change_pulse),
      .coin_reject  (coin_reject),
      .deny         (deny),
      .sold_out     (sold_out),
      .busy         (busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic put_coin(input logic [1:0] c);
      coin = c;
      cyc();
      coin = 2'b00;
   endtask

   task automatic pick(input logic [1:0] s);
      sel_valid = 1'b1;
      sel       = s;
      cyc();
      sel_valid = 1'b0;
   endtask

   task automatic do_cancel();
      cancel = 1'b1;
      cyc();
      cancel = 1'b0;
   endtask

   task automatic ack_disp();
      disp_done = 1'b1;
      cyc();
      disp_done = 1'b0;
   endtask

   // Count change pulses until the controller leaves busy, bounded
   task automatic drain(input string tag, input int exp_n);
      int n = 0;
      for (int i = 0; i < 40; i++) begin
         if (!busy) break;
         cyc();
         if (change_pulse) n++;
      end
      check_eq({tag, "_idle"}, 32'(busy), 32'd0);
      check_eq({tag, "_pulses"}, 32'(n), 32'(exp_n));
      check_eq({tag, "_credit0"}, 32'(credit), 32'd0);
   endtask

   task automatic vend1();
      put_coin(2'b10);
      put_coin(2'b10);
      pick(2'd1);
      ack_disp();
   endtask

   initial begin
      reset = 1'b0; coin = 2'b00; sel_valid = 1'b0; sel = 2'd0;
      cancel = 1'b0; disp_done = 1'b0; restock = 1'b0;
      #12;
      check_eq("rst_credit", 32'(credit), 32'd0);
      check_eq("rst_disp_req", 32'(disp_req), 32'd0);
      check_eq("rst_outs", 32'({change_pulse, coin_reject, deny, busy}), 32'd0);
      check_eq("rst_sold_out", 32'(sold_out), 32'd0);
      @(negedge clk) reset = 1'b1;
      cyc();

      // Selection with zero credit in idle
      pick(2'd0);
      check_eq("idle_sel_deny", 32'(deny), 32'd1);
      check_eq("idle_sel_busy", 32'(busy), 32'd0);
      cyc();
      check_eq("idle_deny_1cyc", 32'(deny), 32'd0);

      // 10c + 5c, buy product 0
      put_coin(2'b10);
      check_eq("a_credit2", 32'(credit), 32'd2);
      put_coin(2'b01);
      check_eq("a_credit3", 32'(credit), 32'd3);
      pick(2'd0);
      check_eq("a_disp_req", 32'(disp_req), 32'd1);
      check_eq("a_disp_item", 32'(disp_item), 32'd0);
      check_eq("a_credit0", 32'(credit), 32'd0);
      check_eq("a_busy", 32'(busy), 32'd1);
      put_coin(2'b01);
      check_eq("a_disp_coin_rej", 32'(coin_reject), 32'd1);
      check_eq("a_disp_req_hold", 32'(disp_req), 32'd1);
      disp_done = 1'b1; cyc(); disp_done = 1'b0;
      check_eq("a_done_req", 32'(disp_req), 32'd0);
      check_eq("a_done_idle", 32'(busy), 32'd0);
      check_eq("a_done_credit", 32'(credit), 32'd0);

      // 30c, buy product 2, one unit of change
      put_coin(2'b10); put_coin(2'b10); put_coin(2'b10);
      check_eq("b_credit6", 32'(credit), 32'd6);
      pick(2'd2);
      check_eq("b_credit1", 32'(credit), 32'd1);
      check_eq("b_item", 32'(disp_item), 32'd2);
      ack_disp();
      check_eq("b_change_state", 32'(busy), 32'd1);
      drain("b", 1);

      // Insufficient credit for product 3, then cancel
      put_coin(2'b10);
      pick(2'd3);
      check_eq("c_deny", 32'(deny), 32'd1);
      check_eq("c_credit2", 32'(credit), 32'd2);
      check_eq("c_no_req", 32'(disp_req), 32'd0);
      do_cancel();
      drain("c", 2);

      // Credit ceiling
      for (int i = 0; i < 7; i++) put_coin(2'b10);
      check_eq("d_credit14", 32'(credit), 32'd14);
      put_coin(2'b10);
      check_eq("d_rej10", 32'(coin_reject), 32'd1);
      check_eq("d_credit14b", 32'(credit), 32'd14);
      put_coin(2'b01);
      check_eq("d_acc5", 32'(coin_reject), 32'd0);
      check_eq("d_credit15", 32'(credit), 32'd15);
      do_cancel();
      drain("d", 15);

      // Coin together with selection: coin rejected, vend proceeds (product 1, vend #1)
      put_coin(2'b10); put_coin(2'b10);
      coin = 2'b10; sel_valid = 1'b1; sel = 2'd1;
      cyc();
      coin = 2'b00; sel_valid = 1'b0;
      check_eq("e_coin_rej", 32'(coin_reject), 32'd1);
      check_eq("e_disp_req", 32'(disp_req), 32'd1);
      check_eq("e_credit0", 32'(credit), 32'd0);
      ack_disp();

      // Sell out product 1
      for (int v = 2; v <= 6; v++) vend1();
      check_eq("f_six_sold", 32'(sold_out), 32'd0);
      vend1();
      check_eq("f_sold_out1", 32'(sold_out), 32'b0010);
      put_coin(2'b10); put_coin(2'b10);
      pick(2'd1);
      check_eq("f_deny8", 32'(deny), 32'd1);
      check_eq("f_credit4", 32'(credit), 32'd4);
      restock = 1'b1; cyc(); restock = 1'b0;
      check_eq("f_restock_ignored", 32'(sold_out), 32'b0010);
      do_cancel();
      drain("f", 4);
      restock = 1'b1; cyc(); restock = 1'b0;
      check_eq("f_restocked", 32'(sold_out), 32'd0);

      // Reset in the middle of a dispense with credit 4
      put_coin(2'b10); put_coin(2'b10); put_coin(2'b10); put_coin(2'b01);
      pick(2'd0);
      check_eq("g_req", 32'(disp_req), 32'd1);
      check_eq("g_credit4", 32'(credit), 32'd4);
      #2 reset = 1'b0;
      #1;
      check_eq("g_rst_credit", 32'(credit), 32'd0);
      check_eq("g_rst_req", 32'(disp_req), 32'd0);
      check_eq("g_rst_busy", 32'(busy), 32'd0);
      check_eq("g_rst_sold", 32'(sold_out), 32'd0);
      @(negedge clk) reset = 1'b1;
      begin
         int n = 0;
         for (int i = 0; i < 10; i++) begin
            cyc();
            if (change_pulse) n++;
         end
         check_eq("g_no_change", 32'(n), 32'd0);
      end
      check_eq("g_post_credit", 32'(credit), 32'd0);
      check_eq("g_post_busy", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 Parameter STOCK_INIT, default 7, stock count loaded into every product slot at reset and on restock (range 1..7).
REQ-002 Parameter CREDIT_MAX, default 15, maximum credit in 5-cent units (range 6..15).
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 coin  input  2  coin strobe, valid one cycle per coin: 2'b01 = 5c (1 unit), 2'b10 = 10c (2 units), 2'b00/2'b11 = no coin.
REQ-006 sel_valid  input  1  one-cycle product-selection strobe.
REQ-007 sel  input  2  product index 0..3, sampled when sel_valid=1.
REQ-008 cancel  input  1  one-cycle request to refund all credit.
REQ-009 disp_done  input  1  dispenser mechanism acknowledge, one cycle.
REQ-010 restock  input  1  one-cycle strobe reloading all stock counts.
REQ-011 credit  output  4  current credit in 5-cent units.
REQ-012 disp_req  output  1  dispense request to mechanism.
REQ-013 disp_item  output  2  product index being dispensed; stable while disp_req=1.
REQ-014 change_pulse  output  1  one pulse per 5-cent unit returned.
REQ-015 coin_reject  output  1  one-cycle pulse when a coin is not accepted.
REQ-016 deny  output  1  one-cycle pulse when a selection is refused.
REQ-017 sold_out  output  4  bit i = 1 when product i stock is 0.
REQ-018 busy  output  1  1 in DISPENSE or CHANGE.

Function
REQ-019 Prices in units: product0=3 (15c), product1=4, product2=5, product3=6.
REQ-020 FSM states IDLE, CREDIT, DISPENSE, CHANGE; state, credit and stock are registered, next-state logic combinational.
REQ-021 IDLE: accepted coin adds its value to credit next cycle and enters CREDIT; sel_valid or cancel with zero credit -> deny/no action, stay IDLE.
REQ-022 CREDIT: coin accepted if credit+value <= CREDIT_MAX, else coin_reject pulses and credit unchanged.
REQ-023 CREDIT, sel_valid: if credit >= price(sel) and stock(sel) > 0, next cycle credit -= price, stock(sel) -= 1, disp_item=sel, disp_req=1, enter DISPENSE; otherwise deny pulses and state/credit unchanged.
REQ-024 CREDIT, cancel: enter CHANGE next cycle; cancel has priority over sel_valid in the same cycle.
REQ-025 Same-cycle coin with sel_valid or cancel in CREDIT: coin rejected (coin_reject pulse), selection/cancel processed.
REQ-026 DISPENSE: disp_req held 1 until the cycle disp_done=1; next cycle disp_req=0 and state = CHANGE if credit>0 else IDLE; disp_done in any other state ignored.
REQ-027 CHANGE: change_pulse=1 and credit decremented by 1 each cycle; on the cycle credit reaches 0, return to IDLE with change_pulse=0; N units yield exactly N consecutive pulses.
REQ-028 Coins in DISPENSE or CHANGE are rejected; sel_valid and cancel ignored (no deny).
REQ-029 restock honoured only in IDLE: all four stock counts = STOCK_INIT next cycle; ignored elsewhere.
REQ-030 sold_out is combinational from stock registers; credit never exceeds CREDIT_MAX nor underflows.

Reset
REQ-031 reset low asynchronously forces state=IDLE, credit=0, all stock=STOCK_INIT, disp_item=0.
REQ-032 During and immediately after reset: disp_req, change_pulse, coin_reject, deny, busy = 0, sold_out=4'b0000; reset mid-DISPENSE or mid-CHANGE discards credit without pulses.

Structure
REQ-033 Shared package vend_pkg holds state encoding, coin codes, price constants and unit widths.
REQ-034 One sub-module vend_stock: four STOCK_INIT-loaded 3-bit down-counters with decrement-select, restock load and sold_out outputs.

Verification
REQ-035 coin 10,5 then sel=0 -> credit 2,3; disp_req=1 item 0; after disp_done credit 0, IDLE, stock0=6.
REQ-036 coin 10,10,10 then sel=2 -> credit 6 -> 1 after vend; after disp_done exactly 1 change_pulse, then IDLE.
REQ-037 credit 2, sel=3 -> deny pulse, credit stays 2; then cancel -> 2 change_pulses, credit 0.
REQ-038 credit 14, coin 10 -> coin_reject, credit 14; coin 5 -> credit 15; coin during DISPENSE -> coin_reject.
REQ-039 vend product1 7 times -> sold_out[1]=1, 8th sel=1 -> deny; restock in IDLE -> sold_out[1]=0.
REQ-040 reset low while disp_req=1 with credit 4 -> all outputs 0, credit 0, stock=7, no change_pulse after release.
